// File: rtl/disp_arb_pkg.sv
// Shared definitions for the dispatcher bundle arbiter: FSM encoding and
// default sizing constants.
package disp_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_IDX_W   = 2;
   localparam int DEF_WDOG_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arbState_t;

endpackage

// File: rtl/disp_rr_picker.sv
// Rotate-priority encoder: first set request at or after the pointer,
// searching circularly.
module disp_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] iReqValid,
   input  logic [IDX_W-1:0]   iPtr,
   output logic [IDX_W-1:0]   oWinner,
   output logic               oAny
);

   function automatic logic [IDX_W-1:0] rotIdx(input logic [IDX_W-1:0] base, input int offs);
      logic [IDX_W:0] sum;
      sum = {1'b0, base} + (IDX_W+1)'(offs);
      if (sum >= (IDX_W+1)'(NUM_REQ))
         sum = sum - (IDX_W+1)'(NUM_REQ);
      return sum[IDX_W-1:0];
   endfunction

   logic [IDX_W-1:0] cand;

   // Walk from the farthest offset down so the nearest valid request wins last.
   always_comb begin
      oWinner = '0;
      oAny    = 1'b0;
      cand    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = rotIdx(iPtr, i);
         if (iReqValid[cand]) begin
            oWinner = cand;
            oAny    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_bundle_arbiter.sv
// Shares one dispatcher executor among NUM_REQ bundle requesters with
// round-robin grants, scratchpad read steering, bundle count and watchdog.
module disp_bundle_arbiter
   import disp_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int WDOG_W  = DEF_WDOG_W
) (
   input  logic                    iClock,
   input  logic                    iReset,
   input  logic [NUM_REQ-1:0]      iReqValid,
   output logic [NUM_REQ-1:0]      oReqPopped,
   output logic                    oExecBundleValid,
   input  logic                    iExecBundleReady,
   input  logic [31:0]             iExecSPReadAddress,
   input  logic                    iExecSPReadValid,
   output logic [31:0]             oExecSPReadData,
   output logic                    oExecSPReadAck,
   output logic [31:0]             oReqSPReadAddress,
   output logic [NUM_REQ-1:0]      oReqSPReadValid,
   input  logic [NUM_REQ*32-1:0]   iReqSPReadData,
   input  logic [NUM_REQ-1:0]      iReqSPReadAck,
   input  logic [WDOG_W-1:0]       iWdogLimit,
   output logic [IDX_W-1:0]        oGrantIdx,
   output logic                    oBusy,
   output logic                    oWdogExpired,
   output logic [31:0]             oBundleCount,
   output logic [1:0]              oDbgState,
   output logic [IDX_W-1:0]        oDbgRrPtr
);

   // Handshake: oExecBundleValid is high for the whole GRANT state and the
   // bundle is consumed on the single cycle iExecBundleReady is sampled high
   // there; oReqPopped[k] pulses one cycle later, after which valid is low
   // for at least two cycles (RELEASE, IDLE) so a halted executor never
   // restarts on a stale grant.

   arbState_t            rState;
   logic [IDX_W-1:0]     rGrant;
   logic [IDX_W-1:0]     rPtr;
   logic [IDX_W-1:0]     nextPtr;
   logic [IDX_W-1:0]     pickIdx;
   logic                 pickAny;
   logic [NUM_REQ-1:0]   rPopped;
   logic [NUM_REQ-1:0]   grantOnehot;
   logic [WDOG_W-1:0]    rWdog;
   logic                 rWdogExpired;
   logic [31:0]          rBundleCount;
   logic                 inGrant;

   disp_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) uPicker (
      .iReqValid (iReqValid),
      .iPtr      (rPtr),
      .oWinner   (pickIdx),
      .oAny      (pickAny)
   );

   assign inGrant = (rState == ST_GRANT);
   assign nextPtr = (rGrant == IDX_W'(NUM_REQ - 1)) ? '0 : rGrant + 1'b1;

   always_comb begin
      grantOnehot = '0;
      grantOnehot[rGrant] = 1'b1;
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         rState       <= ST_IDLE;
         rGrant       <= '0;
         rPtr         <= '0;
         rPopped      <= '0;
         rWdog        <= '0;
         rWdogExpired <= 1'b0;
         rBundleCount <= '0;
      end else begin
         rPopped <= '0;
         case (rState)
            ST_IDLE: begin
               if (pickAny) begin
                  rGrant <= pickIdx;
                  rWdog  <= '0;
                  rState <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // Request drops are ignored here; the grant is held until the pop.
               if (rWdog != '1)
                  rWdog <= rWdog + 1'b1;
               if ((iWdogLimit != '0) && (rWdog == iWdogLimit))
                  rWdogExpired <= 1'b1;
               if (iExecBundleReady) begin
                  rPopped <= grantOnehot;
                  rState  <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               rPtr         <= nextPtr;
               rBundleCount <= rBundleCount + 32'd1;
               rState       <= ST_IDLE;
            end
            default: rState <= ST_IDLE;
         endcase
      end
   end

   // Read data follows the registered grant so the executor's delayed sample
   // of its entry PC still sees the same requester.
   always_comb begin
      oExecSPReadData = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (rGrant == IDX_W'(k))
            oExecSPReadData = iReqSPReadData[k*32 +: 32];
      end
   end

   assign oExecSPReadAck    = inGrant & iReqSPReadAck[rGrant];
   assign oReqSPReadAddress = iExecSPReadAddress;
   assign oReqSPReadValid   = grantOnehot & {NUM_REQ{iExecSPReadValid & inGrant}};

   assign oReqPopped        = rPopped;
   assign oExecBundleValid  = inGrant;
   assign oBusy             = inGrant;
   assign oGrantIdx         = rGrant;
   assign oWdogExpired      = rWdogExpired;
   assign oBundleCount      = rBundleCount;
   assign oDbgState         = rState;
   assign oDbgRrPtr         = rPtr;

endmodule

// File: tb/tb_disp_bundle_arbiter.sv
// Directed bench for disp_bundle_arbiter: grant order, read steering,
// request drop, watchdog, stray pops and mid-grant reset.
module tb_disp_bundle_arbiter;
   import disp_arb_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int WDOG_W  = 16;

   logic                  iClock = 1'b0;
   logic                  iReset;
   logic [NUM_REQ-1:0]    iReqValid;
   logic [NUM_REQ-1:0]    oReqPopped;
   logic                  oExecBundleValid;
   logic                  iExecBundleReady;
   logic [31:0]           iExecSPReadAddress;
   logic                  iExecSPReadValid;
   logic [31:0]           oExecSPReadData;
   logic                  oExecSPReadAck;
   logic [31:0]           oReqSPReadAddress;
   logic [NUM_REQ-1:0]    oReqSPReadValid;
   logic [NUM_REQ*32-1:0] iReqSPReadData;
   logic [NUM_REQ-1:0]    iReqSPReadAck;
   logic [WDOG_W-1:0]     iWdogLimit;
   logic [IDX_W-1:0]      oGrantIdx;
   logic                  oBusy;
   logic                  oWdogExpired;
   logic [31:0]           oBundleCount;
   logic [1:0]            oDbgState;
   logic [IDX_W-1:0]      oDbgRrPtr;

   int nVec = 0;
   int nMis = 0;
   int expCount = 0;

   disp_bundle_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W),
      .WDOG_W  (WDOG_W)
   ) dut (
      .iClock             (iClock),
      .iReset             (iReset),
      .iReqValid          (iReqValid),
      .oReqPopped         (oReqPopped),
      .oExecBundleValid   (oExecBundleValid),
      .iExecBundleReady   (iExecBundleReady),
      .iExecSPReadAddress (iExecSPReadAddress),
      .iExecSPReadValid   (iExecSPReadValid),
      .oExecSPReadData    (oExecSPReadData),
      .oExecSPReadAck     (oExecSPReadAck),
      .oReqSPReadAddress  (oReqSPReadAddress),
      .oReqSPReadValid    (oReqSPReadValid),
      .iReqSPReadData     (iReqSPReadData),
      .iReqSPReadAck      (iReqSPReadAck),
      .iWdogLimit         (iWdogLimit),
      .oGrantIdx          (oGrantIdx),
      .oBusy              (oBusy),
      .oWdogExpired       (oWdogExpired),
      .oBundleCount       (oBundleCount),
      .oDbgState          (oDbgState),
      .oDbgRrPtr          (oDbgRrPtr)
   );

   always #5 iClock = ~iClock;

   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic waitGrant(input string tag, input int expIdx);
      for (int i = 0; i < 20 && !oExecBundleValid; i++) tick();
      chk({tag, "_valid"}, 32'(oExecBundleValid), 32'd1);
      chk({tag, "_grant"}, 32'(oGrantIdx), 32'(expIdx));
   endtask

   task automatic popBundle(input string tag, input int expIdx, input int hold);
      logic [NUM_REQ-1:0] oh;
      oh = 4'b0001 << expIdx;
      repeat (hold) tick();
      chk({tag, "_busy"}, 32'(oBusy), 32'd1);
      chk({tag, "_holdgrant"}, 32'(oGrantIdx), 32'(expIdx));
      iExecBundleReady = 1'b1;
      tick();
      iExecBundleReady = 1'b0;
      expCount++;
      chk({tag, "_popped"}, 32'(oReqPopped), 32'(oh));
      chk({tag, "_rel_valid"}, 32'(oExecBundleValid), 32'd0);
      chk({tag, "_rel_state"}, 32'(oDbgState), 32'(ST_RELEASE));
      tick();
      chk({tag, "_idle_popped"}, 32'(oReqPopped), 32'd0);
      chk({tag, "_idle_valid"}, 32'(oExecBundleValid), 32'd0);
      chk({tag, "_count"}, oBundleCount, 32'(expCount));
   endtask

   initial begin
      iReset = 1'b1;
      iReqValid = '0;
      iExecBundleReady = 1'b0;
      iExecSPReadAddress = '0;
      iExecSPReadValid = 1'b0;
      iReqSPReadData = '0;
      iReqSPReadAck = '0;
      iWdogLimit = '0;
      repeat (3) tick();
      iReset = 1'b0;

      // T1: idle after reset, with a stray executor pop thrown in
      repeat (10) tick();
      chk("t1_valid", 32'(oExecBundleValid), 32'd0);
      chk("t1_busy", 32'(oBusy), 32'd0);
      chk("t1_popped", 32'(oReqPopped), 32'd0);
      chk("t1_grant", 32'(oGrantIdx), 32'd0);
      chk("t1_wdog", 32'(oWdogExpired), 32'd0);
      chk("t1_count", oBundleCount, 32'd0);
      chk("t1_state", 32'(oDbgState), 32'(ST_IDLE));
      chk("t1_rdvalid", 32'(oReqSPReadValid), 32'd0);
      chk("t1_ack", 32'(oExecSPReadAck), 32'd0);
      chk("t1_data", oExecSPReadData, 32'd0);
      iExecBundleReady = 1'b1;
      repeat (3) tick();
      chk("t1_stray_popped", 32'(oReqPopped), 32'd0);
      chk("t1_stray_count", oBundleCount, 32'd0);
      iExecBundleReady = 1'b0;

      // T2: all requesters busy, round-robin 0,1,2,3,0
      iReqValid = 4'b1111;
      for (int b = 0; b < 5; b++) begin
         waitGrant("t2", b % 4);
         popBundle("t2", b % 4, 5);
      end
      chk("t2_ptr", 32'(oDbgRrPtr), 32'd1);

      // T3: read steering with grant 2
      iReqValid = 4'b0100;
      iReqSPReadData = {32'h0000_0DDD, 32'h0000_0100, 32'h0000_0BBB, 32'h0000_0AAA};
      waitGrant("t3", 2);
      iExecSPReadValid = 1'b1;
      iExecSPReadAddress = 32'h0;
      iReqSPReadAck = 4'b1111;
      #1;
      chk("t3_rdvalid", 32'(oReqSPReadValid), 32'h4);
      chk("t3_data", oExecSPReadData, 32'h100);
      chk("t3_addr0", oReqSPReadAddress, 32'h0);
      chk("t3_ack", 32'(oExecSPReadAck), 32'd1);
      iExecSPReadAddress = 32'h0000_0040;
      iReqSPReadAck = 4'b1011;
      #1;
      chk("t3_addr40", oReqSPReadAddress, 32'h40);
      chk("t3_ack_other", 32'(oExecSPReadAck), 32'd0);
      iExecSPReadValid = 1'b0;
      #1;
      chk("t3_rdvalid_off", 32'(oReqSPReadValid), 32'd0);
      popBundle("t3", 2, 1);
      iReqValid = 4'b0000;
      iExecSPReadValid = 1'b1;
      iReqSPReadAck = 4'b1111;
      #1;
      chk("t3_idle_rdvalid", 32'(oReqSPReadValid), 32'd0);
      chk("t3_idle_ack", 32'(oExecSPReadAck), 32'd0);
      chk("t3_idle_data", oExecSPReadData, 32'h100);
      iExecSPReadValid = 1'b0;
      iReqSPReadAck = 4'b0000;

      // T4: requester 2 drops mid-grant, grant held to the pop
      iReqValid = 4'b0100;
      waitGrant("t4", 2);
      tick();
      iReqValid = 4'b0001;
      repeat (3) tick();
      chk("t4_hold_valid", 32'(oExecBundleValid), 32'd1);
      popBundle("t4", 2, 0);
      waitGrant("t4b", 0);
      popBundle("t4b", 0, 2);

      // T5: watchdog disabled, then limit 8 with a 20-cycle bundle
      iReqValid = 4'b0010;
      iWdogLimit = 16'd0;
      waitGrant("t5a", 1);
      popBundle("t5a", 1, 20);
      chk("t5a_wdog", 32'(oWdogExpired), 32'd0);
      iWdogLimit = 16'd8;
      waitGrant("t5b", 1);
      repeat (5) tick();
      chk("t5b_wdog_early", 32'(oWdogExpired), 32'd0);
      repeat (7) tick();
      chk("t5b_wdog_set", 32'(oWdogExpired), 32'd1);
      iReqValid = 4'b0000;
      popBundle("t5b", 1, 8);
      chk("t5b_wdog_sticky", 32'(oWdogExpired), 32'd1);

      // T6: reset mid-grant, together with a pop that must be lost
      iReqValid = 4'b1000;
      waitGrant("t6", 3);
      repeat (2) tick();
      iReset = 1'b1;
      iExecBundleReady = 1'b1;
      tick();
      expCount = 0;
      chk("t6_valid", 32'(oExecBundleValid), 32'd0);
      chk("t6_popped", 32'(oReqPopped), 32'd0);
      chk("t6_state", 32'(oDbgState), 32'(ST_IDLE));
      chk("t6_ptr", 32'(oDbgRrPtr), 32'd0);
      chk("t6_count", oBundleCount, 32'd0);
      chk("t6_wdog", 32'(oWdogExpired), 32'd0);
      iReset = 1'b0;
      iExecBundleReady = 1'b0;
      iReqValid = 4'b1111;
      tick();
      chk("t6_no_pop", 32'(oReqPopped), 32'd0);
      waitGrant("t6b", 0);
      popBundle("t6b", 0, 1);
      iReqValid = 4'b0000;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
